muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file read ports.
- Consumes the rs1/rs2 operand pair plus the destination register index.
- Produces a result/waddr pair for the writeback mux that drives the register file write port.
- One operation in flight; one result bit-step per cycle; valid/ready handshake on both sides.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_operand_prep.sv | 36 +++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 tb/tb_muldiv_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FN_MUL    = 3'b000;
    localparam logic [2:0] FN_MULH   = 3'b001;
    localparam logic [2:0] FN_MULHSU = 3'b010;
    localparam logic [2:0] FN_MULHU  = 3'b011;
    localparam logic [2:0] FN_DIV    = 3'b100;
    localparam logic [2:0] FN_DIVU   = 3'b101;
    localparam logic [2:0] FN_REM    = 3'b110;
    localparam logic [2:0] FN_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between register-file read ports, the unit and writeback.
interface muldiv_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1;
    logic [WIDTH-1:0] rs2;
    logic [AW-1:0]    rd_addr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [AW-1:0]    waddr;

    modport master (
        output in_valid, funct3, rs1, rs2, rd_addr, out_ready,
        input  in_ready, out_valid, result, waddr
    );

    modport slave (
        input  in_valid, funct3, rs1, rs2, rd_addr, out_ready,
        output in_ready, out_valid, result, waddr
    );
endinterface

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning: magnitudes, result-negate flag and divide special cases.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic [WIDTH-1:0] mag_a,
    output logic [WIDTH-1:0] mag_b,
    output logic             neg_res,
    output logic             div_by_zero,
    output logic             signed_overflow
);
    logic a_signed;
    logic b_signed;
    logic a_neg;
    logic b_neg;

    always_comb begin
        a_signed = funct3 inside {FN_MUL, FN_MULH, FN_MULHSU, FN_DIV, FN_REM};
        b_signed = funct3 inside {FN_MUL, FN_MULH, FN_DIV, FN_REM};
        a_neg    = a_signed && rs1[WIDTH-1];
        b_neg    = b_signed && rs2[WIDTH-1];
        mag_a    = a_neg ? -rs1 : rs1;
        mag_b    = b_neg ? -rs2 : rs2;
        // Remainders follow the dividend sign; everything else the product/quotient sign.
        neg_res  = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_by_zero     = funct3[2] && (rs2 == '0);
        signed_overflow = (funct3 inside {FN_DIV, FN_REM})
                          && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div: shift-add multiply, restoring divide, one bit per cycle.
// Latency: WIDTH+1 cycles accept-to-out_valid; divide special cases in 1 cycle.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int AW    = 5
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [AW-1:0]      waddr_q, waddr_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_res, div_by_zero, signed_overflow;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   div_sel, final_res, fast_res;

    muldiv_operand_prep #(.WIDTH(WIDTH)) u_prep (
        .funct3          (bus.funct3),
        .rs1             (bus.rs1),
        .rs2             (bus.rs2),
        .mag_a           (mag_a),
        .mag_b           (mag_b),
        .neg_res         (neg_res),
        .div_by_zero     (div_by_zero),
        .signed_overflow (signed_overflow)
    );

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        if (op_q[2]) begin
            if (!div_trial[WIDTH]) acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else                   acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
        end else if (acc_q[0]) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        prod_fix = neg_q ? -acc_step : acc_step;
        div_sel  = op_q[1] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
        if (op_q[2])               final_res = neg_q ? -div_sel : div_sel;
        else if (op_q == FN_MUL)   final_res = prod_fix[WIDTH-1:0];
        else                       final_res = prod_fix[2*WIDTH-1:WIDTH];
        if (div_by_zero)           fast_res = bus.funct3[1] ? bus.rs1 : ALL_ONES;
        else                       fast_res = bus.funct3[1] ? '0 : bus.rs1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        waddr_d  = waddr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.funct3;
                    neg_d   = neg_res;
                    waddr_d = bus.rd_addr;
                    cnt_d   = '0;
                    if (div_by_zero || signed_overflow) begin
                        result_d = fast_res;
                        state_d  = ST_DONE;
                    end else begin
                        opnd_d  = bus.funct3[2] ? mag_b : mag_a;
                        acc_d   = {{WIDTH{1'b0}}, (bus.funct3[2] ? mag_a : mag_b)};
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = final_res;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            waddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.waddr     = waddr_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, backpressure, mid-op reset, random ops.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int A = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W), .AW(A)) bus ();
    muldiv_unit #(.WIDTH(W), .AW(A)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [W-1:0] res;
        logic [A-1:0] wa;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_model(input logic [2:0] f3, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [63:0] sa, sb;
        logic        [63:0] ua, ub, p;
        logic signed [W-1:0] a32, b32;
        sa = {{32{a[W-1]}}, a};
        sb = {{32{b[W-1]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        a32 = a;
        b32 = b;
        p = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: if (b == 0) return 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                  else return a32 / b32;
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
                  else return a32 % b32;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
        if (f3[2] && (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF && !f3[0])))
            return 1;
        return W + 1;
    endfunction

    // Issue one op, wait for the result, compare against the scoreboard, then hold
    // out_ready low for 'hold' cycles while offering a competing request before draining.
    task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [A-1:0] rd, input int hold);
        exp_t e;
        int   n;
        bit   busy_bad;
        bit   ghost;
        logic [W-1:0] res_seen;
        logic [A-1:0] wa_seen;
        @(negedge clk);
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.funct3   = f3;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.rd_addr  = rd;
        bus.in_valid = 1'b1;
        e.res = ref_model(f3, a, b);
        e.wa  = rd;
        e.lat = exp_latency(f3, a, b);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 1;
        busy_bad = 1'b0;
        while (!bus.out_valid && n < 100) begin
            if (bus.in_ready) busy_bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("result", bus.result, e.res);
            chk("waddr", bus.waddr, e.wa);
            chk("latency", n, e.lat);
            chk("in_ready_while_busy", busy_bad, 0);
        end
        res_seen = bus.result;
        wa_seen  = bus.waddr;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.funct3   = 3'd0;
            bus.rs1      = 32'd9;
            bus.rs2      = 32'd9;
            bus.rd_addr  = 5'd31;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_result", bus.result, res_seen);
            chk("hold_waddr", bus.waddr, wa_seen);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_out_valid", bus.out_valid, 1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("drain_in_ready", bus.in_ready, 1);
        chk("drain_out_valid", bus.out_valid, 0);
        if (hold > 0) begin
            ghost = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
                if (bus.out_valid) ghost = 1'b1;
            end
            chk("ignored_request_no_output", ghost, 0);
        end
    endtask

    logic [2:0]   d_f3[14]  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [W-1:0] d_a[14]   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000,
                                32'd77, 32'd77};
    logic [W-1:0] d_b[14]   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd0, 32'd0};
    logic [W-1:0] d_exp[14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0,
                                32'hFFFF_FFFF, 32'd77};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ghost;
        logic [W-1:0] ra, rb;
        logic [2:0]   rf;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.funct3    = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd_addr   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", bus.in_ready, 1);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_waddr", bus.waddr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed values are hand-derived; also cross-check the reference model.
        for (int i = 0; i < 14; i++) begin
            chk("ref_model_table", ref_model(d_f3[i], d_a[i], d_b[i]), d_exp[i]);
            run_op(d_f3[i], d_a[i], d_b[i], (i == 0) ? 5'd5 : 5'(i + 1), 0);
        end

        run_op(3'd5, 32'd1000, 32'd3, 5'd17, 10);
        run_op(3'd0, 32'd12, 32'd12, 5'd0, 0);

        // Reset partway through an iteration discards the op.
        @(negedge clk);
        bus.funct3   = 3'd0;
        bus.rs1      = 32'd123;
        bus.rs2      = 32'd456;
        bus.rd_addr  = 5'd9;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_in_ready", bus.in_ready, 1);
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_result", bus.result, 0);
        chk("midreset_waddr", bus.waddr, 0);
        @(negedge clk);
        rst = 1'b0;
        ghost = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) ghost = 1'b1;
        end
        chk("midreset_no_output", ghost, 0);
        run_op(3'd3, 32'd3, 32'd5, 5'd4, 0);

        for (int i = 0; i < 16; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom();
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
            if (i == 3) rb = 32'hFFFF_FFFF;
            run_op(rf, ra, rb, 5'($urandom_range(0, 31)), 0);
        end

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
